// File: rtl/store_narrow_pkg.sv
// Shared constants for the store path: opcodes, address map and the FIFO entry layout.
package store_narrow_pkg;

  localparam logic [7:0] StoreWord = 8'h2b;
  localparam logic [7:0] StoreHalf = 8'h29;
  localparam logic [7:0] StoreByte = 8'h28;

  localparam logic [31:0] DmBase     = 32'h0000_0000;
  localparam logic [31:0] DmEnd      = 32'h0000_2fff;
  localparam logic [31:0] Tc0Base    = 32'h0000_7f00;
  localparam logic [31:0] Tc0End     = 32'h0000_7f0b;
  localparam logic [31:0] Tc1Base    = 32'h0000_7f10;
  localparam logic [31:0] Tc1End     = 32'h0000_7f1b;
  localparam logic [31:0] TcCountOff = 32'h0000_0008;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } entry_t;

  function automatic logic in_range(logic [31:0] a, logic [31:0] lo, logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/store_narrow_if.sv
// Request (MEM stage) and bus-bridge handshakes of the store narrowing unit.
interface store_narrow_if;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;

  modport master (
    output req_valid, req_op, req_addr, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_byteen
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_byteen
  );
endinterface

// File: rtl/store_lane_gen.sv
// Combinational store lane generator and AdES checker; also used by the bridge address checker.
module store_lane_gen
  import store_narrow_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  byteen_o,
  output logic        ades_o,
  output logic        known_o
);

  logic misaligned, narrow, in_dm, in_tc, to_count;

  always_comb begin
    wdata_o    = '0;
    byteen_o   = '0;
    known_o    = 1'b0;
    misaligned = 1'b0;
    narrow     = 1'b0;
    in_dm      = in_range(addr_i, DmBase, DmEnd);
    in_tc      = in_range(addr_i, Tc0Base, Tc0End) || in_range(addr_i, Tc1Base, Tc1End);
    to_count   = (addr_i == Tc0Base + TcCountOff) || (addr_i == Tc1Base + TcCountOff);
    case (op_i)
      StoreWord: begin
        known_o    = 1'b1;
        wdata_o    = data_i;
        byteen_o   = 4'b1111;
        misaligned = addr_i[1:0] != 2'b00;
      end
      StoreHalf: begin
        known_o    = 1'b1;
        narrow     = 1'b1;
        wdata_o    = {2{data_i[15:0]}};
        byteen_o   = addr_i[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_i[0];
      end
      StoreByte: begin
        known_o  = 1'b1;
        narrow   = 1'b1;
        wdata_o  = {4{data_i[7:0]}};
        byteen_o = 4'b0001 << addr_i[1:0];
      end
      default: ;
    endcase
    // Timers only accept full-word writes, and their COUNT registers are read-only.
    ades_o = known_o && (misaligned || !(in_dm || in_tc) || (narrow && in_tc) || to_count);
  end

endmodule

// File: rtl/store_narrow.sv
// Store narrowing unit: lane generation, AdES reporting and a 2-entry in-order store FIFO.
module store_narrow
  import store_narrow_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  store_narrow_if.slave bus,
  output logic         exc_ades,
  output logic [31:0]  exc_addr,
  output logic         busy
);

  entry_t      fifo_q [2];
  entry_t      new_entry, head;
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        exc_ades_q, exc_ades_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_byteen;
  logic        lane_ades, lane_known;
  logic        ready, not_empty, accept, push, pop;

  store_lane_gen u_lane_gen (
    .op_i     (bus.req_op),
    .addr_i   (bus.req_addr),
    .data_i   (bus.req_data),
    .wdata_o  (lane_wdata),
    .byteen_o (lane_byteen),
    .ades_o   (lane_ades),
    .known_o  (lane_known)
  );

  always_comb begin
    // Readiness depends on the registered count only; a full FIFO never passes through.
    ready      = count_q != 2'd2;
    not_empty  = count_q != 2'd0;
    accept     = bus.req_valid && ready;
    push       = accept && lane_known && !lane_ades;
    pop        = not_empty && bus.mem_ready;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
    exc_ades_d = accept && lane_ades;
    exc_addr_d = exc_ades_d ? bus.req_addr : exc_addr_q;
    new_entry  = '{addr: {bus.req_addr[31:2], 2'b00}, wdata: lane_wdata, byteen: lane_byteen};
    head       = fifo_q[rd_ptr_q];
  end

  always_comb begin
    bus.req_ready  = ready;
    bus.mem_valid  = not_empty;
    bus.mem_addr   = not_empty ? head.addr : '0;
    bus.mem_wdata  = not_empty ? head.wdata : '0;
    bus.mem_byteen = not_empty ? head.byteen : '0;
    busy           = not_empty;
    exc_ades       = exc_ades_q;
    exc_addr       = exc_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      exc_ades_q <= 1'b0;
      exc_addr_q <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      exc_ades_q <= exc_ades_d;
      exc_addr_q <= exc_addr_d;
      if (push) fifo_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_store_narrow.sv
// Randomized and directed bench for store_narrow with a queue-based scoreboard.
module tb_store_narrow;
  import store_narrow_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        exc_ades, busy;
  logic [31:0] exc_addr;

  store_narrow_if bus ();

  store_narrow dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .exc_ades (exc_ades),
    .exc_addr (exc_addr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } exc_t;

  exp_t        mem_q[$];
  exc_t        exc_q[$];
  int          tests = 0, fails = 0, cyc = 0, occ = 0;
  bit          push_now = 1'b0, started = 1'b0;
  logic [31:0] last_fault = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference: the architectural store rules, written as size/offset arithmetic.
  function automatic void ref_store(input logic [7:0] op, input logic [31:0] a,
                                    input logic [31:0] d, output bit known, output bit fault,
                                    output logic [31:0] wd, output logic [3:0] be);
    bit in_dm  = a <= 32'h2fff;
    bit in_tmr = (a >= 32'h7f00 && a <= 32'h7f0b) || (a >= 32'h7f10 && a <= 32'h7f1b);
    bit is_cnt = (a == 32'h7f08) || (a == 32'h7f18);
    int size;
    int off = int'(a[1:0]);
    bit misal;
    known = 1'b1;
    if (op == StoreWord) size = 4;
    else if (op == StoreHalf) size = 2;
    else if (op == StoreByte) size = 1;
    else begin
      size  = 0;
      known = 1'b0;
    end
    misal = (size == 4) ? (off != 0) : (size == 2) ? (off % 2 != 0) : 1'b0;
    fault = known && (misal || !(in_dm || in_tmr) || (in_tmr && size < 4) || is_cnt);
    wd    = '0;
    be    = '0;
    if (size == 4) begin
      wd = d;
      be = 4'hf;
    end else if (size == 2) begin
      wd = {16'b0, d[15:0]} * 32'h0001_0001;
      be = (off >= 2) ? 4'b1100 : 4'b0011;
    end else if (size == 1) begin
      wd = {24'b0, d[7:0]} * 32'h0101_0101;
      be = 4'(1 << off);
    end
  endfunction

  task automatic drive(input bit v, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] d, input bit mr, output bit acc);
    bit known, fault;
    logic [31:0] wd;
    logic [3:0] be;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.mem_ready = mr;
    #1;
    acc = v && bus.req_ready && !reset;
    if (acc) begin
      ref_store(op, a, d, known, fault, wd, be);
      if (fault) exc_q.push_back('{addr: a, cyc: cyc});
      else if (known) begin
        mem_q.push_back('{addr: {a[31:2], 2'b00}, wdata: wd, be: be});
        push_now = 1'b1;
      end
    end
  endtask

  task automatic idle(input bit mr);
    bit acc;
    drive(1'b0, 8'h00, 32'h0, 32'h0, mr, acc);
  endtask

  task automatic send(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                      input bit mr);
    bit acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) drive(1'b1, op, a, d, mr, acc);
    check1("send_accept", acc, 1'b1);
  endtask

  task automatic expect_head(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    check1("head_valid", bus.mem_valid, 1'b1);
    check("head_addr", bus.mem_addr, a);
    check("head_wdata", bus.mem_wdata, wd);
    check("head_byteen", {28'b0, bus.mem_byteen}, {28'b0, be});
  endtask

  task automatic pulse_reset(input bit with_fault);
    @(negedge clk);
    reset         = 1'b1;
    bus.req_valid = with_fault;
    bus.req_op    = StoreHalf;
    bus.req_addr  = 32'h43;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check1("rst_mem_valid", bus.mem_valid, 1'b0);
    check1("rst_exc_ades", exc_ades, 1'b0);
    check1("rst_req_ready", bus.req_ready, 1'b1);
  endtask

  // Monitor: compares DUT outputs against the model occupancy and expectation queues.
  initial begin
    exp_t e;
    bit   pop, exp_exc;
    wait (started);
    forever begin
      @(negedge clk);
      #2;
      check1("mem_valid", bus.mem_valid, occ != 0);
      check1("busy", busy, occ != 0);
      check1("req_ready", bus.req_ready, occ != 2);
      if (!bus.mem_valid)
        check("idle_bus_zero", bus.mem_addr | bus.mem_wdata | {28'b0, bus.mem_byteen}, 32'h0);
      pop = bus.mem_valid && bus.mem_ready;
      if (pop) begin
        if (mem_q.size() == 0) check1("unexpected_pop", 1'b1, 1'b0);
        else begin
          e = mem_q.pop_front();
          check("pop_addr", bus.mem_addr, e.addr);
          check("pop_wdata", bus.mem_wdata, e.wdata);
          check("pop_byteen", {28'b0, bus.mem_byteen}, {28'b0, e.be});
        end
      end
      exp_exc = exc_q.size() > 0 && exc_q[0].cyc == cyc - 1;
      check1("exc_ades", exc_ades, exp_exc);
      if (exp_exc) last_fault = exc_q.pop_front().addr;
      while (exc_q.size() > 0 && exc_q[0].cyc < cyc - 1) void'(exc_q.pop_front());
      check("exc_addr", exc_addr, last_fault);
      if (reset) begin
        occ = 0;
        mem_q.delete();
        exc_q.delete();
        last_fault = '0;
      end else begin
        occ = occ + int'(push_now) - int'(pop);
      end
      push_now = 1'b0;
    end
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 8'h00;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check1("reset_mem_valid", bus.mem_valid, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_req_ready", bus.req_ready, 1'b1);
    check1("reset_exc_ades", exc_ades, 1'b0);
    check("reset_exc_addr", exc_addr, 32'h0);
    check("reset_mem_bus", bus.mem_addr | bus.mem_wdata | {28'b0, bus.mem_byteen}, 32'h0);
    started = 1'b1;

    send(StoreByte, 32'h13, 32'h1234_56ab, 1'b0);
    idle(1'b0);
    expect_head(32'h10, 32'habab_abab, 4'b1000);
    idle(1'b1);
    send(StoreHalf, 32'h6, 32'hdead_beef, 1'b0);
    idle(1'b0);
    expect_head(32'h4, 32'hbeef_beef, 4'b1100);
    idle(1'b1);
    send(StoreHalf, 32'h5, 32'hdead_beef, 1'b0);
    idle(1'b0);
    check1("sh_odd_ades", exc_ades, 1'b1);
    check("sh_odd_addr", exc_addr, 32'h5);
    check1("sh_odd_no_valid", bus.mem_valid, 1'b0);

    send(StoreWord, 32'h7f08, 32'h1, 1'b0);
    send(StoreWord, 32'h7f04, 32'h2, 1'b0);
    send(StoreByte, 32'h7f14, 32'h3, 1'b0);
    send(StoreWord, 32'h3000, 32'h4, 1'b0);
    idle(1'b1);
    idle(1'b1);

    send(StoreWord, 32'h0, 32'h1111_1111, 1'b0);
    send(StoreWord, 32'h4, 32'h2222_2222, 1'b0);
    idle(1'b0);
    check1("full_not_ready", bus.req_ready, 1'b0);
    send(StoreWord, 32'h8, 32'h3333_3333, 1'b1);
    idle(1'b1);
    idle(1'b1);

    send(StoreWord, 32'h10, 32'haaaa_0010, 1'b0);
    send(StoreWord, 32'h20, 32'haaaa_0020, 1'b1);
    idle(1'b0);
    expect_head(32'h20, 32'haaaa_0020, 4'b1111);
    check1("pushpop_busy", busy, 1'b1);
    idle(1'b1);

    send(StoreWord, 32'h40, 32'h40, 1'b0);
    send(StoreWord, 32'h44, 32'h44, 1'b0);
    pulse_reset(1'b0);
    send(StoreWord, 32'h48, 32'h48, 1'b0);
    pulse_reset(1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [7:0]  op;
      logic [31:0] a;
      bit          acc;
      case ($urandom_range(0, 3))
        0:       op = StoreWord;
        1:       op = StoreHalf;
        2:       op = StoreByte;
        default: op = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0, 1:    a = $urandom_range(0, 32'h3003);
        2:       a = 32'h7f00 + $urandom_range(0, 31);
        default: a = $urandom;
      endcase
      drive($urandom_range(0, 3) != 0, op, a, $urandom, $urandom_range(0, 9) < 7, acc);
    end
    repeat (4) idle(1'b1);
    check("drained_stores", mem_q.size(), 32'd0);
    check("drained_faults", exc_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
# store_narrow

Store-path narrowing unit between the MEM stage and the bus bridge. It performs the inverse of the load/immediate widening path: it takes a 32-bit GPR value plus a store opcode and produces a word-aligned address, lane-replicated write data and byte enables. It also detects AdES (address error on store) conditions and buffers up to two accepted stores in a 2-entry FIFO, decoupling the pipeline from bridge backpressure.

## Interface
- No parameters; depth fixed at 2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: MEM stage presents a store.
- `req_ready` out 1: FIFO not full; a store transfers when `req_valid && req_ready`.
- `req_op` in 8: store opcode, using the `storeWord`/`storeHalf`/`storeByte` codes from constants.v.
- `req_addr` in 32: byte address.
- `req_data` in 32: rt value.
- `exc_ades` out 1: one-cycle AdES pulse.
- `exc_addr` out 32: faulting address; valid while `exc_ades` is high.
- `mem_valid` out 1: FIFO head valid.
- `mem_ready` in 1: bridge accepts head.
- `mem_addr` out 32: `{addr[31:2],2'b00}`.
- `mem_wdata` out 32: lane-replicated data.
- `mem_byteen` out 4: byte enables.
- `busy` out 1: FIFO non-empty.

## Operation
- Lane generation:
  - SW: byteen 4'b1111, wdata = data.
  - SH: byteen = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - SB: byteen = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
- AdES is raised on an accepted store if any of the following holds:
  - SW with addr[1:0] != 0, or SH with addr[0] != 0.
  - Address outside the DM range 0x0000_0000–0x0000_2FFF, timer0 range 0x0000_7F00–0x0000_7F0B, and timer1 range 0x0000_7F10–0x0000_7F1B.
  - SH or SB to either timer range.
  - Any store to a timer COUNT register (offset 0x8, i.e. 0x7F08 or 0x7F18).
- A faulting store is accepted (it consumes the handshake) but is not enqueued.
- Unknown `req_op`: accepted, not enqueued, no exception.
- FIFO is 2 entries, each holding {addr, wdata, byteen}. Strict in-order; the head drives the `mem_*` outputs.
- Pop on `mem_valid && mem_ready`. Push on an accepted, non-faulting, known-op store.
- Full: `req_ready` = 0, even if a pop occurs in the same cycle (no pass-through).
- Push and pop in the same cycle with 1 entry: count stays 1, and the new entry becomes the head next cycle.
- Empty: `mem_valid` = 0. `mem_addr`/`mem_wdata`/`mem_byteen` are driven 0.
- `exc_ades` and `exc_addr` are registered from the accepting cycle. `exc_addr` holds the last fault address until the next fault.

## Timing
- Reset values:
  - `mem_valid` 0, `busy` 0, `req_ready` 1.
  - `exc_ades` 0, `exc_addr` 0.
  - `mem_addr`, `mem_wdata`, `mem_byteen` 0.
  - FIFO count 0; read and write pointers 0.
- Latency: a store accepted in cycle N drives `mem_valid` in cycle N+1 if the FIFO was empty. `exc_ades` pulses in cycle N+1 for exactly one cycle.
- `mem_*` outputs are stable while `mem_valid && !mem_ready`.
- `req_ready` is a registered function of the count only (no combinational path from `mem_ready`).
- Reset mid-operation discards all FIFO entries and any pending exception pulse in the same edge. No store issues after reset.
- Pointers are 1-bit and wrap modulo 2. Count is 2-bit, range 0..2.

## Structure
- Constants in constants.v, shared package:
  - Store opcodes.
  - DM_BASE/DM_END, TC0_BASE/TC0_END, TC1_BASE/TC1_END.
  - TC_COUNT_OFF.
- Sub-module `store_lane_gen`: combinational (op, addr, data) → (wdata, byteen, ades, known). It is reused by the bridge's address checker.
- Top `store_narrow`: FIFO storage, pointers, count, exception register.

## Test plan
- Reset, then SB addr 0x0000_0013, data 0x1234_56AB → cycle+1: `mem_addr` 0x10, byteen 4'b1000, wdata 0xABAB_ABAB, `mem_valid` 1.
- SH addr 0x0000_0006, data 0xDEAD_BEEF → byteen 4'b1100, wdata 0xBEEF_BEEF. SH addr 0x0000_0005 → `exc_ades` pulse, `exc_addr` 0x5, no `mem_valid`.
- SW addr 0x7F08 → AdES. SW addr 0x7F04 → enqueued with byteen 4'b1111. SB addr 0x7F14 → AdES. SW addr 0x3000 → AdES.
- Hold `mem_ready` 0 and push 3 SWs (0x0, 0x4, 0x8) back-to-back → `req_ready` 0 after the second. Release `mem_ready` → drained in order 0x0, 0x4, then 0x8 is accepted after space frees.
- With 1 entry queued, push SW 0x20 while popping → count stays 1, head 0x20 next cycle, `busy` stays 1.
- Assert `reset` with 2 entries queued and an AdES pending → next cycle `mem_valid` 0, `exc_ades` 0, `req_ready` 1.
